register_file_mp: RTL and testbench
===================================

# register_file_mp

Parametrised multi-port register file that succeeds the fixed 16x32 two-read-port design used by the core. It keeps register 0 optionally hard-wired to zero and keeps registered reads. It adds:
- N read ports
- write-to-read forwarding
- a per-register pending-write scoreboard for multicycle producers
- a sequenced bulk-clear engine

It sits between the decode/operand-fetch stage and the writeback stage.

## Interface
- `XLEN`, 32, register width in bits
- `ADDR_BITS`, 4, address width; `DEPTH` = 2^`ADDR_BITS`
- `READ_PORTS`, 2, number of independent read ports (1..4)
- `ZERO_REG`, 1, 1: r0 reads 0, ignores writes/reserves
- `FORWARD`, 1, 1: same-cycle write data bypasses to read ports
- `clk` input 1: clock. One clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high reset
- `write_en_n` input 1: write strobe, active low
- `write_addr` input `ADDR_BITS`: write address
- `write_data` input `XLEN`: write data
- `read_en_n` input 1: shared read strobe for all ports, active low
- `read_addr` input `READ_PORTS*ADDR_BITS`: port p at [p*`ADDR_BITS` +: `ADDR_BITS`]
- `read_data` output `READ_PORTS*XLEN`: registered read data, port p at [p*`XLEN` +: `XLEN`]
- `read_pending` output `READ_PORTS`: registered pending flag for each port's address
- `reserve_en_n` input 1: mark `reserve_addr` as awaiting a write, active low
- `reserve_addr` input `ADDR_BITS`: address to reserve
- `clear_req` input 1: start a bulk clear (level sampled)
- `busy` output 1: clear sequence in progress

## Operation
- **Storage.**
  - `DEPTH` x `XLEN` array plus `pending[DEPTH]`.
  - With `ZERO_REG`=1, address 0 has no storage: it always reads 0 and pending 0, and writes/reserves to it are no-ops.
- **Write.** `write_en_n`=0 and `busy`=0 stores `write_data` at the edge and clears `pending[write_addr]`.
- **Reserve.** `reserve_en_n`=0 and `busy`=0 sets `pending[reserve_addr]`. Reserve and write to the same address in the same cycle: pending ends 1 (new producer wins), and the data is still written.
- **Read.**
  - `read_en_n`=0: each port registers the array value at its address.
  - `read_en_n`=1: `read_data`/`read_pending` hold.
  - With `FORWARD`=1, a port whose address equals a same-cycle valid write address (non-zero when `ZERO_REG`=1) registers `write_data`.
  - With `FORWARD`=0, that port registers the old value.
- **Read pending.** `read_pending[p]` registers the next-state pending bit of its address, so same-cycle write-clear and reserve-set are already reflected.
- **Clear FSM** (states IDLE, CLEAR):
  - IDLE → CLEAR when `clear_req`=1. The sweep index is loaded with the first clearable address (1 if `ZERO_REG`, else 0).
  - In CLEAR, each cycle zeroes `array[idx]` and `pending[idx]`, then increments `idx`. After `DEPTH`-1 is cleared → IDLE.
  - `busy` = (state==CLEAR).
  - While `busy`, writes and reserves are dropped; `clear_req` is ignored; reads proceed and return current contents. Forwarding is inactive because writes are dropped.
  - The sweep index wraps nowhere; it stops at `DEPTH`-1.
- **Reset.** Zeroes all array entries, `pending`, `read_data`, `read_pending`, and `busy`, and forces IDLE. Reset mid-clear aborts the sweep.

## Timing
- Write-to-array latency: 1 edge.
- Read latency: 1 cycle; data is valid the cycle after `read_en_n`=0.
- Read-after-write:
  - same cycle with `FORWARD`=1: new data
  - same cycle with `FORWARD`=0: old data
  - next cycle: new data regardless of `FORWARD`
- Clear:
  - `busy` rises the cycle after `clear_req` is sampled.
  - Clear lasts `DEPTH`-`ZERO_REG` cycles (15 with defaults).
  - The first write accepted is the one presented in the cycle `busy` reads 0.
- Reset values: `read_data`=0, `read_pending`=0, `busy`=0.

## Structure
- Package `register_file_pkg`:
  - `clear_state_t` enum {`CLEAR_IDLE`, `CLEAR_RUN`}
  - the address-0 constant `ZERO_ADDR`
- Sub-module `register_file_clear_fsm`: owns state, sweep index, and `busy`; outputs `clear_we`/`clear_addr` to the array.
- Array, pending vector, and read ports are generated over `DEPTH`/`READ_PORTS` in the top module.

## Test plan
- **Reset and r0.**
  - Stimulus: reset, then write 0xDEADBEEF to r0, then read r0 on all ports.
  - Required: `read_data`=0 and `read_pending`=0 on every port, both before and after the write.
- **Forwarding.**
  - Stimulus: write 0x12345678 to r5 while port 0 reads r5.
  - `FORWARD`=1: the next cycle shows 0x12345678.
  - `FORWARD`=0: the next cycle shows 0, and the following read shows 0x12345678.
- **Scoreboard.**
  - Stimulus: reserve r7, then read r7 → `read_pending`=1.
  - Stimulus: write 0xA5 to r7 with a simultaneous read of r7 → `read_pending`=0 and data 0xA5.
  - Stimulus: reserve and write r7 in the same cycle → pending 1.
- **Bulk clear.**
  - Stimulus: fill r1..r15 with their index, pulse `clear_req`.
  - Required: `busy` is high for exactly 15 cycles; writes during busy are dropped; afterwards all registers and pending bits read 0.
- **Reset mid-clear.**
  - Stimulus: assert reset 5 cycles into a clear.
  - Required: `busy`=0 the next cycle, all registers 0, and a new write is accepted immediately.
- **Multi-port.**
  - Stimulus: `READ_PORTS`=4, the four ports read r1, r2, r1, r0 with r1=0x11, r2=0x22.
  - Required: outputs 0x11, 0x22, 0x11, 0; with `read_en_n`=1 the outputs hold while the addresses change.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared types and constants for the multi-port register file and its clear sequencer.
package register_file_pkg;

    typedef enum logic {
        CLEAR_IDLE,
        CLEAR_RUN
    } clear_state_t;

    localparam int ZERO_ADDR = 0;

endpackage

// File: rtl/register_file_clear_fsm.sv
// Bulk-clear sequencer: sweeps every clearable address once, one per cycle, then returns to idle.
module register_file_clear_fsm
    import register_file_pkg::*;
#(
    parameter int ADDR_BITS = 4,
    parameter int ZERO_REG  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear_req,
    output logic                 busy,
    output logic                 clear_we,
    output logic [ADDR_BITS-1:0] clear_addr,
    output clear_state_t         state
);

    // r0 has no storage when hard-wired, so the sweep starts just above it.
    localparam logic [ADDR_BITS-1:0] FIRST_ADDR =
        (ZERO_REG != 0) ? ADDR_BITS'(ZERO_ADDR + 1) : ADDR_BITS'(ZERO_ADDR);

    logic [ADDR_BITS-1:0] idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR_IDLE;
            idx   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                CLEAR_IDLE: begin
                    if (clear_req) begin
                        state <= CLEAR_RUN;
                        idx   <= FIRST_ADDR;
                        busy  <= 1'b1;
                    end
                end
                CLEAR_RUN: begin
                    if (&idx) begin
                        state <= CLEAR_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= CLEAR_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign clear_we   = (state == CLEAR_RUN);
    assign clear_addr = idx;

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file with registered reads, write forwarding,
// a pending-write scoreboard and a sequenced bulk clear.
module register_file_mp
    import register_file_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDR_BITS  = 4,
    parameter int READ_PORTS = 2,
    parameter int ZERO_REG   = 1,
    parameter int FORWARD    = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            write_en_n,
    input  logic [ADDR_BITS-1:0]            write_addr,
    input  logic [XLEN-1:0]                 write_data,
    input  logic                            read_en_n,
    input  logic [READ_PORTS*ADDR_BITS-1:0] read_addr,
    output logic [READ_PORTS*XLEN-1:0]      read_data,
    output logic [READ_PORTS-1:0]           read_pending,
    input  logic                            reserve_en_n,
    input  logic [ADDR_BITS-1:0]            reserve_addr,
    input  logic                            clear_req,
    output logic                            busy
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [XLEN-1:0]      mem [DEPTH];
    logic [DEPTH-1:0]     pending;
    logic [DEPTH-1:0]     pending_next;
    logic                 clear_we;
    logic [ADDR_BITS-1:0] clear_addr;
    clear_state_t         clear_state;
    logic                 sweeping;
    logic                 write_ok;
    logic                 reserve_ok;

    function automatic logic is_zero_addr(input logic [ADDR_BITS-1:0] a);
        return (ZERO_REG != 0) && (a == ADDR_BITS'(ZERO_ADDR));
    endfunction

    register_file_clear_fsm #(
        .ADDR_BITS (ADDR_BITS),
        .ZERO_REG  (ZERO_REG)
    ) u_clear_fsm (
        .clk        (clk),
        .reset      (reset),
        .clear_req  (clear_req),
        .busy       (busy),
        .clear_we   (clear_we),
        .clear_addr (clear_addr),
        .state      (clear_state)
    );

    // Writes and reserves are dropped for the whole sweep so the clear is never overtaken.
    assign sweeping   = (clear_state == CLEAR_RUN);
    assign write_ok   = !write_en_n && !sweeping && !is_zero_addr(write_addr);
    assign reserve_ok = !reserve_en_n && !sweeping && !is_zero_addr(reserve_addr);

    // Reserve is applied after write-clear, so a new producer wins over a retiring one.
    for (genvar i = 0; i < DEPTH; i++) begin : g_pending
        if ((ZERO_REG != 0) && (i == ZERO_ADDR)) begin : g_zero
            assign pending_next[i] = 1'b0;
        end else begin : g_entry
            assign pending_next[i] =
                (clear_we   && (clear_addr   == ADDR_BITS'(i))) ? 1'b0 :
                (reserve_ok && (reserve_addr == ADDR_BITS'(i))) ? 1'b1 :
                (write_ok   && (write_addr   == ADDR_BITS'(i))) ? 1'b0 :
                pending[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            pending <= '0;
        end else begin
            pending <= pending_next;
            if (clear_we) begin
                mem[clear_addr] <= '0;
            end else if (write_ok) begin
                mem[write_addr] <= write_data;
            end
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
        logic [ADDR_BITS-1:0] addr;
        logic                 fwd;
        logic [XLEN-1:0]      data_q;
        logic                 pend_q;

        assign addr = read_addr[p*ADDR_BITS +: ADDR_BITS];
        assign fwd  = (FORWARD != 0) && write_ok && (write_addr == addr);

        always_ff @(posedge clk) begin
            if (reset) begin
                data_q <= '0;
                pend_q <= 1'b0;
            end else if (!read_en_n) begin
                if (fwd) begin
                    data_q <= write_data;
                end else if (is_zero_addr(addr)) begin
                    data_q <= '0;
                end else begin
                    data_q <= mem[addr];
                end
                pend_q <= pending_next[addr];
            end
        end

        assign read_data[p*XLEN +: XLEN] = data_q;
        assign read_pending[p]           = pend_q;
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: directed vector table, clear/reset sequences,
// and randomized traffic against a behavioural reference model.
module tb_register_file_mp;

    localparam int XLEN = 32;
    localparam int AB   = 4;
    localparam int RP   = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            write_en_n;
    logic [AB-1:0]   write_addr;
    logic [XLEN-1:0] write_data;
    logic            read_en_n;
    logic [RP*AB-1:0]   read_addr;
    logic [RP*XLEN-1:0] read_data;
    logic [RP-1:0]   read_pending;
    logic            reserve_en_n;
    logic [AB-1:0]   reserve_addr;
    logic            clear_req;
    logic            busy;

    int errors = 0;
    int checks = 0;

    register_file_mp #(
        .XLEN(XLEN), .ADDR_BITS(AB), .READ_PORTS(RP), .ZERO_REG(1), .FORWARD(1)
    ) dut (
        .clk(clk), .reset(reset),
        .write_en_n(write_en_n), .write_addr(write_addr), .write_data(write_data),
        .read_en_n(read_en_n), .read_addr(read_addr),
        .read_data(read_data), .read_pending(read_pending),
        .reserve_en_n(reserve_en_n), .reserve_addr(reserve_addr),
        .clear_req(clear_req), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: plain array contents, pending flags, and a queue of addresses still to sweep.
    logic [XLEN-1:0] m_mem  [16];
    logic            m_pend [16];
    int              clr_q [$];
    logic [XLEN-1:0] exp_d  [RP];
    logic            exp_p  [RP];
    logic            exp_busy;

    typedef struct {
        logic          wen_n;
        logic [3:0]    waddr;
        logic [31:0]   wdata;
        logic          ren_n;
        logic [15:0]   raddr;
        logic          res_n;
        logic [3:0]    resaddr;
        logic [127:0]  exp_d;
        logic [3:0]    exp_p;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_step();
        bit mb, wr, rs;
        logic [XLEN-1:0] old_mem [16];
        logic [3:0] ra;
        int a;
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                m_mem[i]  = '0;
                m_pend[i] = 1'b0;
            end
            clr_q.delete();
            for (int p = 0; p < RP; p++) begin
                exp_d[p] = '0;
                exp_p[p] = 1'b0;
            end
            exp_busy = 1'b0;
            return;
        end
        mb = (clr_q.size() != 0);
        wr = !write_en_n && !mb && (write_addr != 0);
        rs = !reserve_en_n && !mb && (reserve_addr != 0);
        old_mem = m_mem;
        if (mb) begin
            a = clr_q.pop_front();
            m_mem[a]  = '0;
            m_pend[a] = 1'b0;
        end else begin
            if (wr) begin
                m_mem[write_addr]  = write_data;
                m_pend[write_addr] = 1'b0;
            end
            if (rs) m_pend[reserve_addr] = 1'b1;
            if (clear_req) for (int i = 1; i < 16; i++) clr_q.push_back(i);
        end
        if (!read_en_n) begin
            for (int p = 0; p < RP; p++) begin
                ra = read_addr[p*AB +: AB];
                exp_d[p] = (wr && ra == write_addr) ? write_data : old_mem[ra];
                exp_p[p] = m_pend[ra];
            end
        end
        exp_busy = (clr_q.size() != 0);
    endtask

    // One clock: advance the model on the current inputs, then compare every output.
    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
        for (int p = 0; p < RP; p++) begin
            chk("model_data", read_data[p*XLEN +: XLEN], exp_d[p]);
            chk("model_pend", 32'(read_pending[p]), 32'(exp_p[p]));
        end
        chk("model_busy", 32'(busy), 32'(exp_busy));
    endtask

    task automatic idle();
        reset        = 1'b0;
        write_en_n   = 1'b1;
        read_en_n    = 1'b1;
        reserve_en_n = 1'b1;
        clear_req    = 1'b0;
    endtask

    task automatic add_vec(input logic wen_n, input logic [3:0] waddr, input logic [31:0] wdata,
                           input logic ren_n, input logic [15:0] raddr,
                           input logic res_n, input logic [3:0] resaddr,
                           input logic [127:0] ed, input logic [3:0] ep);
        vec_t v;
        v.wen_n = wen_n; v.waddr = waddr; v.wdata = wdata;
        v.ren_n = ren_n; v.raddr = raddr;
        v.res_n = res_n; v.resaddr = resaddr;
        v.exp_d = ed; v.exp_p = ep;
        vecs.push_back(v);
    endtask

    initial begin
        int busy_cnt;
        int guard;
        vec_t v;

        idle();
        write_addr = '0; write_data = '0; read_addr = '0; reserve_addr = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_pending", 32'(read_pending), 32'd0);
        for (int p = 0; p < RP; p++) chk("reset_data", read_data[p*XLEN +: XLEN], 32'd0);

        //       wen  waddr  wdata         ren  raddr     res  radr exp_d {p3,p2,p1,p0}                                           exp_p
        add_vec(1'b0, 4'd0, 32'hDEADBEEF, 1'b0, 16'h0000, 1'b1, 4'd0, 128'd0, 4'b0000);
        add_vec(1'b1, 4'd0, 32'h0,        1'b0, 16'h0000, 1'b1, 4'd0, 128'd0, 4'b0000);
        add_vec(1'b0, 4'd5, 32'h12345678, 1'b0, 16'h5555, 1'b1, 4'd0, {4{32'h12345678}}, 4'b0000);
        add_vec(1'b1, 4'd0, 32'h0,        1'b0, 16'h5555, 1'b1, 4'd0, {4{32'h12345678}}, 4'b0000);
        add_vec(1'b1, 4'd0, 32'h0,        1'b1, 16'h7777, 1'b0, 4'd7, {4{32'h12345678}}, 4'b0000);
        add_vec(1'b1, 4'd0, 32'h0,        1'b0, 16'h7777, 1'b1, 4'd0, 128'd0, 4'b1111);
        add_vec(1'b0, 4'd7, 32'hA5,       1'b0, 16'h7777, 1'b1, 4'd0, {4{32'hA5}}, 4'b0000);
        add_vec(1'b0, 4'd7, 32'hB6,       1'b0, 16'h7777, 1'b0, 4'd7, {4{32'hB6}}, 4'b1111);
        add_vec(1'b1, 4'd0, 32'h0,        1'b0, 16'h7777, 1'b1, 4'd0, {4{32'hB6}}, 4'b1111);
        add_vec(1'b0, 4'd1, 32'h11,       1'b0, 16'h1111, 1'b1, 4'd0, {4{32'h11}}, 4'b0000);
        add_vec(1'b0, 4'd2, 32'h22,       1'b0, 16'h2222, 1'b1, 4'd0, {4{32'h22}}, 4'b0000);
        add_vec(1'b1, 4'd0, 32'h0,        1'b0, 16'h0121, 1'b1, 4'd0, {32'h0, 32'h11, 32'h22, 32'h11}, 4'b0000);
        add_vec(1'b1, 4'd0, 32'h0,        1'b1, 16'h7755, 1'b1, 4'd0, {32'h0, 32'h11, 32'h22, 32'h11}, 4'b0000);
        add_vec(1'b1, 4'd0, 32'h0,        1'b0, 16'h7755, 1'b1, 4'd0, {32'hB6, 32'hB6, 32'h12345678, 32'h12345678}, 4'b1100);

        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            write_en_n = v.wen_n; write_addr = v.waddr; write_data = v.wdata;
            read_en_n = v.ren_n; read_addr = v.raddr;
            reserve_en_n = v.res_n; reserve_addr = v.resaddr;
            tick();
            for (int p = 0; p < RP; p++) begin
                chk("vec_data", read_data[p*XLEN +: XLEN], v.exp_d[p*32 +: 32]);
                chk("vec_pend", 32'(read_pending[p]), 32'(v.exp_p[p]));
            end
        end
        idle();

        // Bulk clear with r1..r15 holding their index and one outstanding reservation.
        for (int i = 1; i < 16; i++) begin
            write_en_n = 1'b0; write_addr = 4'(i); write_data = 32'(i);
            tick();
        end
        idle();
        reserve_en_n = 1'b0; reserve_addr = 4'd9;
        tick();
        idle();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        busy_cnt = busy ? 1 : 0;
        guard = 0;
        while (busy && guard < 40) begin
            write_en_n = 1'b0; write_addr = 4'd3; write_data = 32'hFF;
            reserve_en_n = 1'b0; reserve_addr = 4'd5;
            clear_req = 1'b1;
            tick();
            if (busy) busy_cnt++;
            guard++;
        end
        idle();
        chk("clear_busy_cycles", 32'(busy_cnt), 32'd15);
        chk("clear_done", 32'(busy), 32'd0);
        for (int b = 0; b < 16; b += 4) begin
            read_en_n = 1'b0;
            read_addr = {4'(b + 3), 4'(b + 2), 4'(b + 1), 4'(b)};
            tick();
            for (int p = 0; p < RP; p++) begin
                chk("clear_data", read_data[p*XLEN +: XLEN], 32'd0);
                chk("clear_pend", 32'(read_pending[p]), 32'd0);
            end
        end
        write_en_n = 1'b0; write_addr = 4'd4; write_data = 32'h44;
        read_en_n = 1'b0; read_addr = 16'h4444;
        tick();
        chk("post_clear_write", read_data[0 +: XLEN], 32'h44);
        idle();

        // Reset five cycles into a clear aborts the sweep.
        for (int i = 1; i < 4; i++) begin
            write_en_n = 1'b0; write_addr = 4'(i); write_data = 32'(i * 16'h101);
            tick();
        end
        idle();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midclear_busy", 32'(busy), 32'd0);
        write_en_n = 1'b0; write_addr = 4'd6; write_data = 32'h66;
        read_en_n = 1'b0; read_addr = 16'h6666;
        tick();
        chk("midclear_write_fwd", read_data[0 +: XLEN], 32'h66);
        idle();
        read_en_n = 1'b0; read_addr = 16'h6321;
        tick();
        chk("midclear_r1", read_data[0 +: XLEN], 32'd0);
        chk("midclear_r2", read_data[XLEN +: XLEN], 32'd0);
        chk("midclear_r3", read_data[2*XLEN +: XLEN], 32'd0);
        chk("midclear_r6", read_data[3*XLEN +: XLEN], 32'h66);
        idle();

        // Randomized traffic, occasionally starting clears and resets.
        for (int n = 0; n < 400; n++) begin
            reset        = ($urandom_range(0, 149) == 0);
            write_en_n   = 1'($urandom_range(0, 1));
            write_addr   = 4'($urandom_range(0, 15));
            write_data   = $urandom;
            read_en_n    = ($urandom_range(0, 3) == 0);
            read_addr    = 16'($urandom);
            reserve_en_n = ($urandom_range(0, 3) != 0);
            reserve_addr = 4'($urandom_range(0, 15));
            clear_req    = ($urandom_range(0, 49) == 0);
            tick();
        end
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
